// File: rtl/sudoku_hex2bin_stream.sv
// sudoku_hex2bin_stream
// Takes a sudoku grid as a stream of hex digits, LANES cells per beat. Each cell is
// decoded to an N-bit one-hot value and the grid is assembled in a buffer. The finished
// grid is then held on the output, together with error and blank counts, until the
// consumer takes it.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready, and a grid
// transfers where out_valid && out_ready. in_ready depends only on state, never on
// in_valid. Once out_valid is high it stays high with stable data until the grid is taken.
module sudoku_hex2bin_stream #(
    parameter int N     = 9,
    parameter int HW    = 4,
    parameter int LANES = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*HW-1:0]         in_hex,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N*N*N-1:0]            out_bin,
    output logic [1:0]                  out_err,
    output logic [$clog2(N*N+1)-1:0]    out_blanks,
    output logic                        dbg_state
);

    localparam int CELLS = N * N;
    localparam int BEATS = CELLS / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BLW   = $clog2(CELLS + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [HW-1:0] MAX_DIGIT = HW'(N);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [BW-1:0]      r_beat;
    logic [CELLS*N-1:0] r_buf;
    logic [BLW-1:0]     r_blanks;
    logic [1:0]         r_err;

    logic               w_fire;
    logic               w_take;
    logic               w_final;
    logic               w_misaligned;
    logic [LANES*N-1:0] w_cells;
    logic [BLW-1:0]     w_beat_blanks;
    logic               w_beat_illegal;

    // Beat and grid transfers are qualified by state so the handshake has no comb loop.
    assign w_fire       = in_valid && (r_state == S_FILL);
    assign w_take       = out_ready && (r_state == S_HOLD);
    assign w_final      = (r_beat == LAST_BEAT);
    assign w_misaligned = in_last ^ w_final;

    // Decode each lane: 1..N to one-hot, 0 to blank, anything above N to an error.
    always_comb begin
        w_cells        = '0;
        w_beat_blanks  = '0;
        w_beat_illegal = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (in_hex[k*HW +: HW] == '0) begin
                w_beat_blanks = w_beat_blanks + BLW'(1);
            end else if (in_hex[k*HW +: HW] <= MAX_DIGIT) begin
                w_cells[k*N +: N] = N'(1) << (in_hex[k*HW +: HW] - HW'(1));
            end else begin
                w_beat_illegal = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs: FILL accepts beats, HOLD presents the grid.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid && w_final) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_FILL;
                end
            end
            default: w_next_state = S_FILL;
        endcase
    end

    // Grid buffer, beat counter and statistics; a taken grid leaves everything cleared.
    always_ff @(posedge clk) begin
        if (reset || w_take) begin
            r_beat   <= '0;
            r_buf    <= '0;
            r_blanks <= '0;
            r_err    <= '0;
        end else if (w_fire) begin
            for (int k = 0; k < LANES; k++) begin
                r_buf[(int'(r_beat) * LANES + k) * N +: N] <= w_cells[k*N +: N];
            end
            r_blanks <= r_blanks + w_beat_blanks;
            r_err[0] <= r_err[0] | w_beat_illegal;
            r_err[1] <= r_err[1] | w_misaligned;
            // The counter parks on the final beat; the take clears it.
            if (!w_final) begin
                r_beat <= r_beat + BW'(1);
            end
        end
    end

    // Results are visible only while the grid is held.
    assign out_bin    = (r_state == S_HOLD) ? r_buf    : '0;
    assign out_err    = (r_state == S_HOLD) ? r_err    : '0;
    assign out_blanks = (r_state == S_HOLD) ? r_blanks : '0;
    assign dbg_state  = (r_state == S_HOLD);

endmodule

// File: tb/tb_sudoku_hex2bin_stream.sv
// Bench for sudoku_hex2bin_stream: a 9x9 instance for directed and random grids and a
// 4x4 instance (HW=3, LANES=2) for a long random run, both checked against a reference
// model that builds each expected grid straight from the cell digits.
module tb_sudoku_hex2bin_stream;

    localparam int CW = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- 9x9 instance ----------------
    logic         in_valid9, in_ready9, in_last9, out_valid9, out_ready9, dbg_state9;
    logic [11:0]  in_hex9;
    logic [728:0] out_bin9;
    logic [1:0]   out_err9;
    logic [6:0]   out_blanks9;

    sudoku_hex2bin_stream #(.N(9), .HW(4), .LANES(3)) u_dut9 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid9), .in_ready(in_ready9), .in_hex(in_hex9), .in_last(in_last9),
        .out_valid(out_valid9), .out_ready(out_ready9), .out_bin(out_bin9),
        .out_err(out_err9), .out_blanks(out_blanks9), .dbg_state(dbg_state9)
    );

    // ---------------- 4x4 instance ----------------
    logic         in_valid4, in_ready4, in_last4, out_valid4, out_ready4, dbg_state4;
    logic [5:0]   in_hex4;
    logic [63:0]  out_bin4;
    logic [1:0]   out_err4;
    logic [4:0]   out_blanks4;

    sudoku_hex2bin_stream #(.N(4), .HW(3), .LANES(2)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_hex(in_hex4), .in_last(in_last4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_bin(out_bin4),
        .out_err(out_err4), .out_blanks(out_blanks4), .dbg_state(dbg_state4)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [728:0] exp_bin9_q[$];
    logic [1:0]   exp_err9_q[$];
    logic [6:0]   exp_blk9_q[$];
    logic [63:0]  exp_bin4_q[$];
    logic [1:0]   exp_err4_q[$];
    logic [4:0]   exp_blk4_q[$];

    int g_cells[81];
    bit g_last[27];
    int g4_cells[16];
    bit g4_last[8];

    int n_sent9 = 0, n_got9 = 0, n_sent4 = 0, n_got4 = 0;
    int rdy_mode9 = 0, rdy_mode4 = 0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model9();
        logic [728:0] b = '0;
        logic [1:0]   e = '0;
        int           blk = 0;
        for (int c = 0; c < 81; c++) begin
            if (g_cells[c] == 0) blk++;
            else if (g_cells[c] <= 9) b[c*9 + g_cells[c] - 1] = 1'b1;
            else e[0] = 1'b1;
        end
        for (int i = 0; i < 27; i++) if (g_last[i] != (i == 26)) e[1] = 1'b1;
        exp_bin9_q.push_back(b);
        exp_err9_q.push_back(e);
        exp_blk9_q.push_back(7'(blk));
    endfunction

    function automatic void model4();
        logic [63:0] b = '0;
        logic [1:0]  e = '0;
        int          blk = 0;
        for (int c = 0; c < 16; c++) begin
            if (g4_cells[c] == 0) blk++;
            else if (g4_cells[c] <= 4) b[c*4 + g4_cells[c] - 1] = 1'b1;
            else e[0] = 1'b1;
        end
        for (int i = 0; i < 8; i++) if (g4_last[i] != (i == 7)) e[1] = 1'b1;
        exp_bin4_q.push_back(b);
        exp_err4_q.push_back(e);
        exp_blk4_q.push_back(5'(blk));
    endfunction

    // Valid sudoku with a digit rotation s, in_last on the final beat only.
    function automatic void fill_shift9(input int s);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                g_cells[r*9 + c] = ((r*3 + r/3 + c + s) % 9) + 1;
        for (int b = 0; b < 27; b++) g_last[b] = (b == 26);
    endfunction

    // ---------------- drivers ----------------
    task automatic send_beat9(input logic [11:0] hex, input logic last, input int gap_pct);
        int t = 0;
        if ($urandom_range(0, 99) < gap_pct) begin
            in_valid9 = 1'b0;
            in_hex9   = 12'($urandom);
            in_last9  = 1'($urandom);
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        in_valid9 = 1'b1;
        in_hex9   = hex;
        in_last9  = last;
        while (!in_ready9 && t < 500) begin @(posedge clk); #1; t++; end
        if (t >= 500) check("dut9 in_ready wait cycles", CW'(t), CW'(0));
        @(posedge clk); #1;
    endtask

    task automatic send_cells_beat9(input int b, input int gap_pct);
        logic [11:0] h;
        for (int k = 0; k < 3; k++) h[k*4 +: 4] = 4'(g_cells[b*3 + k]);
        send_beat9(h, g_last[b], gap_pct);
    endtask

    task automatic send_grid9(input int gap_pct);
        model9();
        n_sent9++;
        for (int b = 0; b < 27; b++) begin
            send_cells_beat9(b, gap_pct);
            if (b < 26) check("dut9 no early valid", CW'(out_valid9), CW'(0));
        end
        in_valid9 = 1'b0;
    endtask

    task automatic send_beat4(input logic [5:0] hex, input logic last, input int gap_pct);
        int t = 0;
        if ($urandom_range(0, 99) < gap_pct) begin
            in_valid4 = 1'b0;
            in_hex4   = 6'($urandom);
            in_last4  = 1'($urandom);
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        in_valid4 = 1'b1;
        in_hex4   = hex;
        in_last4  = last;
        while (!in_ready4 && t < 500) begin @(posedge clk); #1; t++; end
        if (t >= 500) check("dut4 in_ready wait cycles", CW'(t), CW'(0));
        @(posedge clk); #1;
    endtask

    task automatic send_grid4(input int gap_pct);
        logic [5:0] h;
        model4();
        n_sent4++;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 2; k++) h[k*3 +: 3] = 3'(g4_cells[b*2 + k]);
            send_beat4(h, g4_last[b], gap_pct);
            if (b < 7) check("dut4 no early valid", CW'(out_valid4), CW'(0));
        end
        in_valid4 = 1'b0;
    endtask

    // ---------------- consumer back-pressure ----------------
    initial begin
        out_ready9 = 1'b1;
        out_ready4 = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode9 == 1)      out_ready9 = ($urandom_range(0, 2) != 0);
            else if (rdy_mode9 == 2) out_ready9 = 1'b0;
            else                     out_ready9 = 1'b1;
            if (rdy_mode4 == 1)      out_ready4 = ($urandom_range(0, 2) != 0);
            else                     out_ready4 = 1'b1;
        end
    end

    // ---------------- monitors ----------------
    logic         prev_hold9 = 1'b0, prev_hold4 = 1'b0;
    logic [728:0] prev_bin9;
    logic [1:0]   prev_err9, prev_err4;
    logic [6:0]   prev_blk9;
    logic [63:0]  prev_bin4;
    logic [4:0]   prev_blk4;

    initial begin
        forever begin
            @(negedge clk);
            check("dut9 dbg_state vs out_valid", CW'(dbg_state9), CW'(out_valid9));
            if (out_valid9) begin
                check("dut9 in_ready in hold", CW'(in_ready9), CW'(0));
                if (prev_hold9) begin
                    check("dut9 bin stable", CW'(out_bin9), CW'(prev_bin9));
                    check("dut9 err stable", CW'(out_err9), CW'(prev_err9));
                    check("dut9 blanks stable", CW'(out_blanks9), CW'(prev_blk9));
                end
            end else begin
                check("dut9 no retraction", CW'(prev_hold9), CW'(0));
                check("dut9 bin zero in fill", CW'(out_bin9), CW'(0));
                check("dut9 err zero in fill", CW'(out_err9), CW'(0));
                check("dut9 blanks zero in fill", CW'(out_blanks9), CW'(0));
            end
            if (out_valid9 && out_ready9) begin
                if (exp_bin9_q.size() == 0) begin
                    check("dut9 unexpected grid, queue size", CW'(exp_bin9_q.size()), CW'(1));
                end else begin
                    check("dut9 out_bin", CW'(out_bin9), CW'(exp_bin9_q.pop_front()));
                    check("dut9 out_err", CW'(out_err9), CW'(exp_err9_q.pop_front()));
                    check("dut9 out_blanks", CW'(out_blanks9), CW'(exp_blk9_q.pop_front()));
                end
                n_got9++;
            end
            prev_hold9 = out_valid9 && !out_ready9;
            prev_bin9  = out_bin9;
            prev_err9  = out_err9;
            prev_blk9  = out_blanks9;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("dut4 dbg_state vs out_valid", CW'(dbg_state4), CW'(out_valid4));
            if (out_valid4) begin
                check("dut4 in_ready in hold", CW'(in_ready4), CW'(0));
                if (prev_hold4) begin
                    check("dut4 bin stable", CW'(out_bin4), CW'(prev_bin4));
                    check("dut4 err stable", CW'(out_err4), CW'(prev_err4));
                    check("dut4 blanks stable", CW'(out_blanks4), CW'(prev_blk4));
                end
            end else begin
                check("dut4 no retraction", CW'(prev_hold4), CW'(0));
                check("dut4 bin zero in fill", CW'(out_bin4), CW'(0));
            end
            if (out_valid4 && out_ready4) begin
                if (exp_bin4_q.size() == 0) begin
                    check("dut4 unexpected grid, queue size", CW'(exp_bin4_q.size()), CW'(1));
                end else begin
                    check("dut4 out_bin", CW'(out_bin4), CW'(exp_bin4_q.pop_front()));
                    check("dut4 out_err", CW'(out_err4), CW'(exp_err4_q.pop_front()));
                    check("dut4 out_blanks", CW'(out_blanks4), CW'(exp_blk4_q.pop_front()));
                end
                n_got4++;
            end
            prev_hold4 = out_valid4 && !out_ready4;
            prev_bin4  = out_bin4;
            prev_err4  = out_err4;
            prev_blk4  = out_blanks4;
        end
    end

    // ---------------- random phases ----------------
    task automatic random9(input int grids);
        int r;
        rdy_mode9 = 1;
        for (int g = 0; g < grids; g++) begin
            for (int c = 0; c < 81; c++) begin
                r = $urandom_range(0, 19);
                if (r < 3)       g_cells[c] = 0;
                else if (r == 3) g_cells[c] = $urandom_range(10, 15);
                else             g_cells[c] = $urandom_range(1, 9);
            end
            for (int b = 0; b < 27; b++) g_last[b] = (b == 26);
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 26);
                g_last[r] = ~g_last[r];
            end
            send_grid9(30);
        end
    endtask

    task automatic random4(input int grids);
        int r;
        rdy_mode4 = 1;
        for (int g = 0; g < grids; g++) begin
            for (int c = 0; c < 16; c++) begin
                r = $urandom_range(0, 19);
                if (r < 3)       g4_cells[c] = 0;
                else if (r == 3) g4_cells[c] = $urandom_range(5, 7);
                else             g4_cells[c] = $urandom_range(1, 4);
            end
            for (int b = 0; b < 8; b++) g4_last[b] = (b == 7);
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 7);
                g4_last[r] = ~g4_last[r];
            end
            send_grid4(30);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [728:0] held_bin;

    initial begin
        reset     = 1'b1;
        in_valid9 = 1'b0; in_hex9 = '0; in_last9 = 1'b0;
        in_valid4 = 1'b0; in_hex4 = '0; in_last4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("reset out_valid", CW'(out_valid9), CW'(0));
        check("reset in_ready", CW'(in_ready9), CW'(1));
        check("reset out_bin", CW'(out_bin9), CW'(0));
        check("reset out_err", CW'(out_err9), CW'(0));
        check("reset out_blanks", CW'(out_blanks9), CW'(0));
        check("reset dut4 in_ready", CW'(in_ready4), CW'(1));

        // 1: solved grid, out_valid in the cycle after the final beat, for one cycle
        fill_shift9(0);
        send_grid9(0);
        check("t1 out_valid after final beat", CW'(out_valid9), CW'(1));
        check("t1 out_err", CW'(out_err9), CW'(0));
        check("t1 out_blanks", CW'(out_blanks9), CW'(0));
        @(posedge clk); #1;
        check("t1 out_valid one cycle", CW'(out_valid9), CW'(0));
        check("t1 in_ready after take", CW'(in_ready9), CW'(1));

        // 2: 20 blanks plus an illegal digit in cell 40
        fill_shift9(1);
        for (int c = 0; c < 20; c++) g_cells[c] = 0;
        g_cells[40] = 10;
        send_grid9(0);
        check("t2 out_blanks", CW'(out_blanks9), CW'(20));
        check("t2 out_err", CW'(out_err9), CW'(2'b01));
        check("t2 cell 40", CW'(out_bin9[360 +: 9]), CW'(0));
        @(posedge clk); #1;

        // 3: consumer stalls for 10 cycles, then a back-to-back grid
        rdy_mode9 = 2;
        fill_shift9(3);
        send_grid9(0);
        held_bin = out_bin9;
        for (int i = 0; i < 10; i++) begin
            check("t3 in_ready while stalled", CW'(in_ready9), CW'(0));
            check("t3 out_valid while stalled", CW'(out_valid9), CW'(1));
            check("t3 out_bin while stalled", CW'(out_bin9), CW'(held_bin));
            @(posedge clk); #1;
        end
        rdy_mode9  = 0;
        out_ready9 = 1'b1;
        @(posedge clk); #1;
        check("t3 in_ready after take", CW'(in_ready9), CW'(1));
        check("t3 out_valid after take", CW'(out_valid9), CW'(0));
        fill_shift9(4);
        send_grid9(0);
        check("t3 second grid valid", CW'(out_valid9), CW'(1));
        @(posedge clk); #1;

        // 4: in_last early on beat 5 and missing on beat 26
        fill_shift9(2);
        for (int b = 0; b < 27; b++) g_last[b] = (b == 5);
        send_grid9(0);
        check("t4 out_valid", CW'(out_valid9), CW'(1));
        check("t4 out_err", CW'(out_err9), CW'(2'b10));
        @(posedge clk); #1;

        // 5: reset after beat 12 discards the partial grid
        for (int c = 0; c < 81; c++) g_cells[c] = (c % 3 == 0) ? 0 : ((c % 3 == 1) ? 12 : 3);
        for (int b = 0; b < 27; b++) g_last[b] = (b == 4);
        for (int b = 0; b < 13; b++) send_cells_beat9(b, 0);
        in_valid9 = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5 out_valid after reset", CW'(out_valid9), CW'(0));
        check("t5 in_ready after reset", CW'(in_ready9), CW'(1));
        check("t5 out_blanks after reset", CW'(out_blanks9), CW'(0));
        fill_shift9(7);
        send_grid9(0);
        check("t5 out_valid", CW'(out_valid9), CW'(1));
        check("t5 out_err", CW'(out_err9), CW'(0));
        check("t5 out_blanks", CW'(out_blanks9), CW'(0));
        @(posedge clk); #1;

        // 6: random gaps and back-pressure on both instances
        fork
            random9(100);
            random4(200);
        join
        rdy_mode9 = 0;
        rdy_mode4 = 0;
        for (int t = 0; t < 1000 && !(n_got9 == n_sent9 && n_got4 == n_sent4); t++) @(posedge clk);
        check("dut9 grids received", CW'(n_got9), CW'(n_sent9));
        check("dut4 grids received", CW'(n_got4), CW'(n_sent4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
